// File: rtl/cpu_trace_pkg.sv
// ---------------------------------------------------------------------------
// cpu_trace_pkg
// Shared definitions for the CPU retirement trace buffer: the capture state
// encoding, the bit layout of one stored trace entry, and a helper that packs
// the retirement fields into that layout.
//
// Entry layout, MSB to LSB:
//   pc[32] | instr[32] | rw[1] | mw[1] | reg[5] | data[32]   (ENTRY_W = 103)
//
// Optional build macro used by cpu_trace_buffer: TRACE_FILTER_EN
// ---------------------------------------------------------------------------
package cpu_trace_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } trace_state_t;

  // Field widths
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int RW_W    = 1;
  localparam int MW_W    = 1;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;

  // Field offsets (LSB position of each field)
  localparam int DATA_LSB  = 0;
  localparam int REG_LSB   = DATA_LSB + DATA_W;
  localparam int MW_LSB    = REG_LSB + REG_W;
  localparam int RW_LSB    = MW_LSB + MW_W;
  localparam int INSTR_LSB = RW_LSB + RW_W;
  localparam int PC_LSB    = INSTR_LSB + INSTR_W;
  localparam int ENTRY_W   = PC_LSB + PC_W;

  typedef logic [ENTRY_W-1:0] trace_entry_t;

  // Packs one retirement record; the data field carries the register
  // write-back value when a register write happened, otherwise the store data.
  function automatic trace_entry_t pack_entry(
    input logic [PC_W-1:0]    pc,
    input logic [INSTR_W-1:0] instr,
    input logic               rw,
    input logic               mw,
    input logic [REG_W-1:0]   rg,
    input logic [DATA_W-1:0]  reg_data,
    input logic [DATA_W-1:0]  mem_data
  );
    trace_entry_t e;
    e = '0;
    e[PC_LSB    +: PC_W]    = pc;
    e[INSTR_LSB +: INSTR_W] = instr;
    e[RW_LSB    +: RW_W]    = rw;
    e[MW_LSB    +: MW_W]    = mw;
    e[REG_LSB   +: REG_W]   = rg;
    e[DATA_LSB  +: DATA_W]  = rw ? reg_data : mem_data;
    return e;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// ---------------------------------------------------------------------------
// trace_ram
// Simple dual-port storage for the trace buffer: one synchronous write port
// and one read port with a registered output. The read register only updates
// when i-side read enable is high, so a fetched word is held until the next
// read is issued (the readout logic relies on this to prefetch).
//
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable (rdata loads mem[raddr] on the next edge)
//   raddr  - read address
//   rdata  - registered read data
// ---------------------------------------------------------------------------
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 103,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: contents are never reset, a new arm simply overwrites them.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read port, held between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/cpu_trace_buffer.sv
// ---------------------------------------------------------------------------
// cpu_trace_buffer
// Circular trace buffer for retired CPU instructions. After arm, every
// qualified retirement is written into a DEPTH-entry ring. A retirement whose
// PC matches trig_pc (with trig_en) is the trigger; POST_TRIG more samples are
// then captured, after which the stored trace is streamed out oldest-first on
// a valid/ready interface.
//
// Parameters:
//   DEPTH     - entries stored (power of two, >= 4)
//   POST_TRIG - samples captured after the trigger sample (<= DEPTH-1)
//
// Build macro:
//   TRACE_FILTER_EN - when defined, only retirements with RegWrite or
//                     MemWrite qualify (for both capture and trigger).
//
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   ret_valid, pc_next, IM_out     - retirement strobe, PC, instruction
//   RegWrite, write_reg, write_data- register write-back
//   MemWrite, write_mem            - store event
//   arm, abort, trig_en, trig_pc   - control
//   rd_valid, rd_data, rd_last     - readout stream (out)
//   rd_ready                       - readout stream (in)
//   busy, triggered, done          - status
// ---------------------------------------------------------------------------
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ret_valid,
  input  logic [31:0]        pc_next,
  input  logic [31:0]        IM_out,
  input  logic               RegWrite,
  input  logic [4:0]         write_reg,
  input  logic [31:0]        write_data,
  input  logic               MemWrite,
  input  logic [31:0]        write_mem,
  input  logic               arm,
  input  logic               abort,
  input  logic               trig_en,
  input  logic [31:0]        trig_pc,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_last,
  input  logic               rd_ready,
  output logic               busy,
  output logic               triggered,
  output logic               done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR   = AW'(1);
  localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
  localparam bit            NO_POST   = (POST_TRIG == 0);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpu_trace_buffer: DEPTH must be a power of two and at least 4");
  end
  if (POST_TRIG < 0 || POST_TRIG > DEPTH - 1) begin : g_bad_post
    $error("cpu_trace_buffer: POST_TRIG must be in 0..DEPTH-1");
  end

  trace_state_t r_state;
  trace_state_t w_next_state;

  logic [AW-1:0]      r_wr_ptr;
  logic [AW:0]        r_count;
  logic [AW-1:0]      r_post_cnt;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_fetch_left;
  logic [AW:0]        r_out_left;
  logic               r_ram_vld;
  logic               r_rd_valid;
  logic               r_rd_last;
  logic [ENTRY_W-1:0] r_rd_data;

  logic               w_filter_ok;
  logic               w_qual;
  logic               w_trig_hit;
  logic               w_post_end;
  logic               w_xfer;
  logic               w_load;
  logic               w_ram_re;
  logic               w_ram_we;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_ram_rdata;

`ifdef TRACE_FILTER_EN
  assign w_filter_ok = RegWrite | MemWrite;
`else
  assign w_filter_ok = 1'b1;
`endif

  assign w_qual     = ret_valid && w_filter_ok &&
                      (r_state == S_ARMED || r_state == S_POST);
  assign w_trig_hit = w_qual && (r_state == S_ARMED) && trig_en &&
                      (pc_next == trig_pc);
  assign w_post_end = w_qual && (r_state == S_POST) && (r_post_cnt == ONE_PTR);

  assign w_entry  = pack_entry(pc_next, IM_out, RegWrite, MemWrite, write_reg,
                               write_data, write_mem);
  assign w_ram_we = w_qual && !abort;

  // Readout pipeline: the RAM output register acts as a prefetch stage in
  // front of the rd_data register. The output stage loads whenever it is
  // empty or being emptied this cycle, and a new RAM read is issued whenever
  // the prefetch stage is empty or being consumed, so rd_data only changes on
  // a transfer and back-to-back transfers need no bubble.
  assign w_xfer   = r_rd_valid && rd_ready;
  assign w_load   = (r_state == S_DRAIN) && r_ram_vld && (!r_rd_valid || w_xfer);
  assign w_ram_re = (r_state == S_DRAIN) && (r_fetch_left != '0) &&
                    (!r_ram_vld || w_load);

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_trace_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (r_wr_ptr),
    .wdata (w_entry),
    .re    (w_ram_re),
    .raddr (r_rd_ptr),
    .rdata (w_ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status decode. abort overrides every other event.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    triggered    = 1'b0;
    done         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (arm) w_next_state = S_ARMED;
      end
      S_ARMED: begin
        busy = 1'b1;
        if (w_trig_hit) w_next_state = NO_POST ? S_DONE : S_POST;
      end
      S_POST: begin
        busy      = 1'b1;
        triggered = 1'b1;
        if (w_post_end) w_next_state = S_DONE;
      end
      S_DONE: begin
        triggered    = 1'b1;
        done         = 1'b1;
        w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        triggered = 1'b1;
        done      = 1'b1;
        if (w_xfer && r_rd_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase

    if (abort) w_next_state = S_IDLE;
  end

  // Capture pointers, post-trigger counter and readout datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_post_cnt   <= '0;
      r_rd_ptr     <= '0;
      r_fetch_left <= '0;
      r_out_left   <= '0;
      r_ram_vld    <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_data    <= '0;
    end else if (abort) begin
      r_count      <= '0;
      r_post_cnt   <= '0;
      r_fetch_left <= '0;
      r_out_left   <= '0;
      r_ram_vld    <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && arm) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end

      if (w_qual) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
        if (r_count != FULL_CNT) r_count <= r_count + ONE_CNT;
      end

      if (w_trig_hit) begin
        r_post_cnt <= POST_LOAD;
      end else if (w_qual && r_state == S_POST) begin
        r_post_cnt <= r_post_cnt - ONE_PTR;
      end

      // Oldest entry sits at 0 until the ring has wrapped, then at wr_ptr.
      if (r_state == S_DONE) begin
        r_rd_ptr     <= (r_count == FULL_CNT) ? r_wr_ptr : '0;
        r_fetch_left <= r_count;
        r_out_left   <= r_count;
        r_ram_vld    <= 1'b0;
      end

      if (r_state == S_DRAIN) begin
        if (w_ram_re) begin
          r_rd_ptr     <= r_rd_ptr + ONE_PTR;
          r_fetch_left <= r_fetch_left - ONE_CNT;
        end
        r_ram_vld <= w_ram_re || (r_ram_vld && !w_load);

        if (w_load) begin
          r_rd_data  <= w_ram_rdata;
          r_rd_valid <= 1'b1;
          r_rd_last  <= (r_out_left == ONE_CNT);
          r_out_left <= r_out_left - ONE_CNT;
        end else if (w_xfer) begin
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
        end
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign rd_data  = r_rd_data;

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning trace entries stored; must be a power of two and at least 4.
REQ-002 SHALL have parameter POST_TRIG, default 32, meaning samples captured after the trigger sample; must be at most DEPTH-1, checked at elaboration.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ret_valid, input, 1 bit: one instruction retired this cycle.
REQ-006 SHALL have ports pc_next and IM_out, input, 32 bits each: retired PC and instruction.
REQ-007 SHALL have ports RegWrite (1 bit), write_reg (5 bits) and write_data (32 bits), all inputs: register write-back.
REQ-008 SHALL have ports MemWrite (1 bit) and write_mem (32 bits), both inputs: store event.
REQ-009 SHALL have ports arm, abort and trig_en (1 bit each) and trig_pc (32 bits), all inputs: control.
REQ-010 SHALL have outputs rd_valid (1 bit), rd_data (ENTRY_W bits) and rd_last (1 bit), plus input rd_ready (1 bit): readout stream.
REQ-011 SHALL have outputs busy, triggered and done, 1 bit each: status.

Function
REQ-012 Entry layout SHALL be, MSB to LSB: pc[32], instr[32], rw[1], mw[1], reg[5], data[32], so ENTRY_W = 103.
REQ-013 The data field SHALL be write_data when RegWrite=1, otherwise write_mem.
REQ-014 A sample SHALL be qualified when ret_valid=1 in state ARMED or POST; each qualified sample is written at wr_ptr.
REQ-015 On each qualified sample, wr_ptr SHALL increment modulo DEPTH, and count SHALL increment, saturating at DEPTH.
REQ-016 The state machine SHALL have exactly five states: IDLE, ARMED, POST, DONE, DRAIN.
REQ-017 IDLE to ARMED SHALL occur on arm=1; this transition clears wr_ptr and count. arm SHALL be ignored in every other state.
REQ-018 ARMED to POST SHALL occur when a qualified sample has trig_en=1 and pc_next==trig_pc; the trigger sample is stored and post_cnt is loaded with POST_TRIG.
REQ-019 In POST, each qualified sample SHALL decrement post_cnt. The state SHALL move to DONE on the sample that brings post_cnt to 0, or immediately after the trigger sample when POST_TRIG=0.
REQ-020 DONE to DRAIN SHALL occur the next cycle; rd_valid SHALL first assert in DRAIN.
REQ-021 Readout SHALL be oldest-first. The start index is 0 if count<DEPTH, else wr_ptr; exactly count entries are output.
REQ-022 An entry SHALL transfer when rd_valid && rd_ready. rd_data SHALL be held stable while rd_valid && !rd_ready.
REQ-023 rd_last SHALL be 1 only on the final entry. The transfer of that entry SHALL return the block to IDLE with rd_valid=0.
REQ-024 abort=1 SHALL force IDLE and count=0 from any state on the next edge; abort wins over a simultaneous trigger, sample or transfer.
REQ-025 busy SHALL be 1 in ARMED and POST; triggered SHALL be 1 in POST, DONE and DRAIN; done SHALL be 1 in DONE and DRAIN.

Reset
REQ-026 While rst_n=0 the block SHALL be in IDLE with wr_ptr, count and post_cnt at 0 and rd_valid, rd_last, rd_data, busy, triggered and done all at 0.
REQ-027 Reset asserted mid-capture or mid-drain SHALL discard the trace; buffer RAM contents need not be cleared.

Configuration
REQ-028 With macro TRACE_FILTER_EN defined, a sample SHALL qualify only if it also has RegWrite=1 or MemWrite=1; the trigger compare applies to qualified samples only.
REQ-029 Without TRACE_FILTER_EN, every ret_valid cycle in ARMED or POST SHALL be captured.

Structure
REQ-030 Package cpu_trace_pkg SHALL hold the state encoding, the field offsets and widths, and ENTRY_W.
REQ-031 Storage SHALL be one sub-module, trace_ram: simple dual-port, DEPTH x ENTRY_W, synchronous write, registered read. The readout logic SHALL prefetch so that REQ-022 holds.

Verification (DEPTH=8, POST_TRIG=3, filter off unless stated)
REQ-032 Basic capture: arm; samples pc=0x00,0x04,...,0x14; trig_pc=0x08 -> DONE after pc 0x14; 6 entries read out, pc 0x00..0x14; rd_last on the 6th.
REQ-033 Wrap-around: 20 samples pc=4*i with trig_pc=0x40 (i=16) -> 8 entries read out, first pc 0x30, last pc 0x4C.
REQ-034 Backpressure: in DRAIN, hold rd_ready=0 for 4 cycles -> rd_data and rd_valid unchanged; no entry skipped or duplicated.
REQ-035 Abort and simultaneity: abort in POST -> next cycle IDLE, busy=0, triggered=0, rd_valid=0; abort together with the trigger sample -> IDLE.
REQ-036 Filter: TRACE_FILTER_EN defined; 10 samples alternating RegWrite=1/0 -> only the 5 write samples are stored; a trigger on an unqualified sample is ignored.
REQ-037 Reset: rst_n pulsed low mid-POST -> all outputs 0 immediately; a subsequent arm restarts with count=0.
